// File: rtl/morse_pkg.sv
// Shared types, unit lengths and the (count, elements) -> letter table for the Morse decoder.
package morse_pkg;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, DRAIN} state_e;

  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

  localparam logic [2:0] DOT_UNITS        = 3'd1;
  localparam logic [2:0] DASH_UNITS       = 3'd3;
  localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS   = 3'd7;
  localparam logic [2:0] RUN_SAT          = 3'd4;
  localparam logic [2:0] MAX_ELEMS        = 3'd4;

  typedef enum logic [4:0] {
    LTR_A, LTR_B, LTR_C, LTR_D, LTR_E, LTR_F, LTR_G, LTR_H, LTR_I,
    LTR_J, LTR_K, LTR_L, LTR_M, LTR_N, LTR_O, LTR_P, LTR_Q, LTR_R,
    LTR_S, LTR_T, LTR_U, LTR_V, LTR_W, LTR_X, LTR_Y, LTR_Z
  } letter_e;

  typedef struct packed {
    logic    hit;
    letter_e letter;
  } lookup_t;

  // Elements sit right-aligned in the low `count` bits; the first element sent is the most significant.
  function automatic lookup_t lookup_letter(input logic [2:0] count, input logic [3:0] elems);
    lookup_t r;
    r.hit    = 1'b1;
    r.letter = LTR_A;
    case ({count, elems})
      {3'd1, 4'b0000}: r.letter = LTR_E;
      {3'd1, 4'b0001}: r.letter = LTR_T;
      {3'd2, 4'b0000}: r.letter = LTR_I;
      {3'd2, 4'b0001}: r.letter = LTR_A;
      {3'd2, 4'b0010}: r.letter = LTR_N;
      {3'd2, 4'b0011}: r.letter = LTR_M;
      {3'd3, 4'b0000}: r.letter = LTR_S;
      {3'd3, 4'b0001}: r.letter = LTR_U;
      {3'd3, 4'b0010}: r.letter = LTR_R;
      {3'd3, 4'b0011}: r.letter = LTR_W;
      {3'd3, 4'b0100}: r.letter = LTR_D;
      {3'd3, 4'b0101}: r.letter = LTR_K;
      {3'd3, 4'b0110}: r.letter = LTR_G;
      {3'd3, 4'b0111}: r.letter = LTR_O;
      {3'd4, 4'b0000}: r.letter = LTR_H;
      {3'd4, 4'b0001}: r.letter = LTR_V;
      {3'd4, 4'b0010}: r.letter = LTR_F;
      {3'd4, 4'b0100}: r.letter = LTR_L;
      {3'd4, 4'b0110}: r.letter = LTR_P;
      {3'd4, 4'b0111}: r.letter = LTR_J;
      {3'd4, 4'b1000}: r.letter = LTR_B;
      {3'd4, 4'b1001}: r.letter = LTR_X;
      {3'd4, 4'b1010}: r.letter = LTR_C;
      {3'd4, 4'b1011}: r.letter = LTR_Y;
      {3'd4, 4'b1100}: r.letter = LTR_Z;
      {3'd4, 4'b1101}: r.letter = LTR_Q;
      default:         r.hit    = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Time-unit strobe: one-cycle Tick every DIVISOR clocks from a reloading down-counter.
module morse_tick_gen #(
  parameter int DIVISOR = 250
) (
  input  logic ClockIn,
  input  logic Reset,
  output logic Tick
);

  localparam int            CW     = $clog2(DIVISOR);
  localparam logic [CW-1:0] RELOAD = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output up front so no path can infer a latch.
  always_comb begin
    cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

  assign Tick = (cnt_q == '0);

endmodule

// File: rtl/morse_decoder.sv
// Morse letter decoder: classifies key-down runs into dots/dashes and decodes on a letter gap.
// Optional word-gap detection on WordEnd is enabled by defining MORSE_WORD_GAP_EN.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int DIVISOR = 250
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       DotDashIn,
  output logic [4:0] Letter,
  output logic       Valid,
  output logic       Error,
  output logic       WordEnd
);

  logic tick;

  morse_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .Tick    (tick)
  );

  state_e     state_q, state_d;
  logic [2:0] run_q, run_d;
  logic [2:0] gap_q, gap_d;
  logic [2:0] count_q, count_d;
  logic [3:0] elems_q, elems_d;
  logic [4:0] letter_q, letter_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  lookup_t    lk;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    gap_d    = gap_q;
    count_d  = count_q;
    elems_d  = elems_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    lk       = lookup_letter(count_q, elems_q);
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (DotDashIn) begin
            state_d = MARK;
            run_d   = 3'd1;
          end
        end
        MARK: begin
          if (DotDashIn) begin
            if (run_q != RUN_SAT) run_d = run_q + 3'd1;
          end else if ((run_q == DOT_UNITS || run_q == DASH_UNITS) && count_q != MAX_ELEMS) begin
            elems_d = {elems_q[2:0], (run_q == DASH_UNITS) ? ELEM_DASH : ELEM_DOT};
            count_d = count_q + 3'd1;
            gap_d   = 3'd1;
            state_d = SPACE;
          end else begin
            // The low sample that ended the bad run already counts toward the drain gap.
            error_d = 1'b1;
            elems_d = '0;
            count_d = '0;
            gap_d   = 3'd1;
            state_d = DRAIN;
          end
        end
        SPACE: begin
          if (!DotDashIn) begin
            gap_d = gap_q + 3'd1;
            if (gap_q + 3'd1 == LETTER_GAP_UNITS) begin
              if (lk.hit) begin
                letter_d = lk.letter;
                valid_d  = 1'b1;
              end else begin
                error_d = 1'b1;
              end
              elems_d = '0;
              count_d = '0;
              gap_d   = '0;
              state_d = IDLE;
            end
          end else if (gap_q == 3'd1) begin
            state_d = MARK;
            run_d   = 3'd1;
          end else begin
            error_d = 1'b1;
            elems_d = '0;
            count_d = '0;
            gap_d   = '0;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (DotDashIn) begin
            gap_d = '0;
          end else if (gap_q + 3'd1 == LETTER_GAP_UNITS) begin
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      run_q    <= '0;
      gap_q    <= '0;
      count_q  <= '0;
      elems_q  <= '0;
      letter_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      gap_q    <= gap_d;
      count_q  <= count_d;
      elems_q  <= elems_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign Letter = letter_q;
  assign Valid  = valid_q;
  assign Error  = error_q;

`ifdef MORSE_WORD_GAP_EN
  // Word gap continues the letter gap: counting starts at 3 when a letter completes.
  logic       letter_done;
  logic [2:0] wgap_q, wgap_d;
  logic       armed_q, armed_d;
  logic       word_end_q, word_end_d;

  assign letter_done = tick && (state_q == SPACE) && !DotDashIn &&
                       (gap_q + 3'd1 == LETTER_GAP_UNITS);

  always_comb begin
    wgap_d     = wgap_q;
    armed_d    = armed_q;
    word_end_d = 1'b0;
    if (letter_done) begin
      armed_d = 1'b1;
      wgap_d  = LETTER_GAP_UNITS;
    end else if (tick && armed_q && state_q == IDLE) begin
      if (DotDashIn) begin
        armed_d = 1'b0;
      end else begin
        wgap_d = wgap_q + 3'd1;
        if (wgap_q + 3'd1 == WORD_GAP_UNITS) begin
          word_end_d = 1'b1;
          armed_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      wgap_q     <= '0;
      armed_q    <= 1'b0;
      word_end_q <= 1'b0;
    end else begin
      wgap_q     <= wgap_d;
      armed_q    <= armed_d;
      word_end_q <= word_end_d;
    end
  end

  assign WordEnd = word_end_q;
`else
  assign WordEnd = 1'b0;
`endif

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 SHALL have parameter DIVISOR, default 250, ClockIn cycles per Morse time unit (legal range 2..256).
REQ-002 SHALL have port ClockIn, input, 1, the single clock.
REQ-003 SHALL have port Reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port DotDashIn, input, 1, Morse line level (1 = key down), synchronous to ClockIn.
REQ-005 SHALL have port Letter, output, 5, decoded letter code (A=0 ... Z=25).
REQ-006 SHALL have port Valid, output, 1, one-cycle pulse: Letter updated.
REQ-007 SHALL have port Error, output, 1, one-cycle pulse: malformed symbol discarded.
REQ-008 SHALL have port WordEnd, output, 1, one-cycle pulse on word gap (MORSE_WORD_GAP_EN only; tied 0 otherwise).

Function
REQ-009 SHALL generate an internal Tick: down-counter loads DIVISOR-1, Tick=1 for one cycle when counter==0, then reloads.
REQ-010 SHALL sample DotDashIn only on Tick cycles; all FSM, run and gap counters advance only on Tick.
REQ-011 SHALL use states IDLE, MARK, SPACE, DRAIN.
REQ-012 IDLE: sample 1 -> MARK, run=1; sample 0 -> stay.
REQ-013 MARK: sample 1 -> run+1, saturating at 4; sample 0 -> classify run (1 = dot, 3 = dash, other = error).
REQ-014 On a valid element, SHALL shift it into the 4-bit element register (dash=1, dot=0), increment count (0..4), go SPACE with gap=1.
REQ-015 A 5th element, or run of 2 or >=4, SHALL raise Error, clear elements/count, go DRAIN.
REQ-016 SPACE: sample 0 -> gap+1; on gap reaching 3, SHALL look up (count, elements), go IDLE.
REQ-017 SPACE: sample 1 with gap==1 -> MARK, run=1; sample 1 with gap==2 -> Error, go DRAIN.
REQ-018 Lookup hit SHALL load Letter and pulse Valid; a miss (e.g. ".-.-") SHALL pulse Error, Letter unchanged.
REQ-019 DRAIN: SHALL wait for 3 consecutive 0 samples (any 1 restarts the count), then go IDLE; no Valid during DRAIN.
REQ-020 Valid/Error/WordEnd SHALL be registered on the Tick cycle's edge: high exactly the following ClockIn cycle; never simultaneous Valid and Error.
REQ-021 Letter SHALL hold its value between Valid pulses.
REQ-022 Decode latency: Valid high 1 ClockIn cycle after the Tick sampling the 3rd gap unit.

Reset
REQ-023 Reset SHALL asynchronously force: state IDLE, run/gap/count/elements 0, tick counter DIVISOR-1, Letter 0, Valid 0, Error 0, WordEnd 0.
REQ-024 Reset mid-symbol SHALL discard the partial letter with no Valid/Error pulse after release.

Configuration
REQ-025 Macro MORSE_WORD_GAP_EN SHALL, when defined, continue gap counting in IDLE after a letter and pulse WordEnd once when total gap reaches 7 units; re-arm only after next MARK.
REQ-026 Without MORSE_WORD_GAP_EN, WordEnd SHALL be constant 0 and no word-gap counter SHALL exist.

Structure
REQ-027 Package morse_pkg SHALL hold: FSM state enum, element encoding constants, letter code constants (A=0..Z=25), unit lengths (DOT=1, DASH=3, LETTER_GAP=3, WORD_GAP=7), and the (count, elements) -> letter lookup function.
REQ-028 Tick generation SHALL be sub-module morse_tick_gen (ClockIn, Reset, Tick); decoder FSM stays in morse_decoder.

Verification (DIVISOR=4)
REQ-029 "E": 1 unit high, 3 low -> Valid once, Letter=4, Error=0.
REQ-030 "Q" (--.-): 3H1L3H1L1H1L3H3L -> Valid, Letter=16; Valid cycle = Tick of 3rd gap unit + 1.
REQ-031 Run of 2 units high, then 3 low -> Error pulse, no Valid, FSM back in IDLE; next "T" (3H3L) -> Letter=19.
REQ-032 Five dots (1H1L x5) -> Error on 5th element; DRAIN ignores until 3 lows; next "A" -> Letter=0.
REQ-033 Reset asserted mid "S" after 2 dots -> all outputs 0 immediately; after release "S" sent fully -> Letter=18.
REQ-034 With MORSE_WORD_GAP_EN: "E" then 7 low units -> Valid (Letter=4) then one WordEnd at unit 7; without macro WordEnd stays 0.
